// File: rtl/sa_if.sv
// ----------------------------------------------------------------------------
// sa_if: request/grant/credit bundle between the input units and the
// switch allocator of a 5-port wormhole router.
//
// Port order for every 5-bit vector: 0=north 1=east 2=south 3=west 4=local.
//   req, is_head, is_tail   per-input flit status at the buffer head
//   outport_<dir>           one-hot requested output of each input
//   credit_in               per-output credit return pulse
//   sa_grant                one-hot granted input (also the buffer dequeue)
//   grant_outport           one-hot output taken by the granted flit
//   credit_avail            per-output "credit count > 0"
//   credit_err              sticky credit overflow flag (SA_CREDIT_ERR_EN only)
//
// Modports: master = input units / environment, slave = allocator.
// Optional feature macro: SA_CREDIT_ERR_EN.
// ----------------------------------------------------------------------------
interface sa_if;
  logic [4:0] req;
  logic [4:0] is_head;
  logic [4:0] is_tail;
  logic [4:0] outport_north;
  logic [4:0] outport_east;
  logic [4:0] outport_south;
  logic [4:0] outport_west;
  logic [4:0] outport_local;
  logic [4:0] credit_in;
  logic [4:0] sa_grant;
  logic [4:0] grant_outport;
  logic [4:0] credit_avail;
`ifdef SA_CREDIT_ERR_EN
  logic       credit_err;
`endif

  modport master (
    output req, is_head, is_tail,
    output outport_north, outport_east, outport_south, outport_west, outport_local,
    output credit_in,
`ifdef SA_CREDIT_ERR_EN
    input  credit_err,
`endif
    input  sa_grant, grant_outport, credit_avail
  );

  modport slave (
    input  req, is_head, is_tail,
    input  outport_north, outport_east, outport_south, outport_west, outport_local,
    input  credit_in,
`ifdef SA_CREDIT_ERR_EN
    output credit_err,
`endif
    output sa_grant, grant_outport, credit_avail
  );
endinterface

// File: rtl/switch_allocator.sv
// ----------------------------------------------------------------------------
// switch_allocator: wormhole switch allocator feeding the crossbar.
//
// Each cycle it picks at most one input (round-robin from rr_ptr) whose
// flit can legally advance, and drives the one-hot sa_grant / grant_outport
// combinationally (zero-cycle grant + dequeue). Per output it tracks a packet
// lock (head flit locks, tail flit releases) and a downstream credit count.
//
// Ports:
//   clk   single clock, all state updates on the rising edge
//   rst   synchronous, active-high reset
//   sa    sa_if.slave bundle (requests, outports, credits, grants)
//
// Parameter BUF_DEPTH: downstream buffer depth = initial/maximum credits.
// Optional feature macro SA_CREDIT_ERR_EN adds the sticky credit_err output
// (credit returned while the count is already full and not being consumed).
// ----------------------------------------------------------------------------
module switch_allocator #(
  parameter int BUF_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  sa_if.slave sa
);

  localparam int            CW       = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(BUF_DEPTH);
  localparam logic [CW-1:0] CRED_ONE = CW'(1);
  localparam logic [CW-1:0] CRED_ZERO = CW'(0);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  logic [2:0]    rr_ptr_r;
  logic [2:0]    rr_ptr_next_s;
  lock_state_e   state_r      [5];
  lock_state_e   state_next_s [5];
  logic [2:0]    owner_r      [5];
  logic [2:0]    owner_next_s [5];
  logic [CW-1:0] credit_r      [5];
  logic [CW-1:0] credit_next_s [5];

  logic [4:0]    outport_s [5];
  logic [2:0]    tgt_s     [5];
  logic [4:0]    avail_s;
  logic [4:0]    eligible_s;
  logic          grant_valid_s;
  logic [2:0]    grant_idx_s;
  logic [4:0]    grant_s;
  logic [4:0]    grant_outport_s;

  // True when v has exactly one bit set.
  function automatic logic onehot5(input logic [4:0] v);
    return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
  endfunction

  // Index of the set bit of a one-hot vector (highest set bit otherwise).
  function automatic logic [2:0] idx5(input logic [4:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int b = 0; b < 5; b++) begin
      if (v[b]) r = 3'(b);
      else      r = r;
    end
    return r;
  endfunction

  assign outport_s[0] = sa.outport_north;
  assign outport_s[1] = sa.outport_east;
  assign outport_s[2] = sa.outport_south;
  assign outport_s[3] = sa.outport_west;
  assign outport_s[4] = sa.outport_local;

  // Per-output credit availability.
  always_comb begin
    avail_s = 5'd0;
    for (int o = 0; o < 5; o++) begin
      avail_s[o] = (credit_r[o] != CRED_ZERO);
    end
  end

  // Eligibility: valid one-hot route, a credit downstream, and either a head
  // flit to an idle output or a flit of the packet that owns the output.
  always_comb begin
    eligible_s = 5'd0;
    for (int i = 0; i < 5; i++) begin
      tgt_s[i] = idx5(outport_s[i]);
      if (sa.req[i] && onehot5(outport_s[i]) && avail_s[tgt_s[i]]) begin
        if (state_r[tgt_s[i]] == IDLE && sa.is_head[i]) begin
          eligible_s[i] = 1'b1;
        end else if (state_r[tgt_s[i]] == LOCKED && owner_r[tgt_s[i]] == 3'(i)) begin
          eligible_s[i] = 1'b1;
        end else begin
          eligible_s[i] = 1'b0;
        end
      end else begin
        eligible_s[i] = 1'b0;
      end
    end
  end

  // Round-robin pick: first eligible input at or after rr_ptr, wrapping 4 -> 0.
  always_comb begin
    logic [3:0] sum;
    logic [2:0] cand;
    grant_valid_s = 1'b0;
    grant_idx_s   = 3'd0;
    for (int k = 0; k < 5; k++) begin
      sum = {1'b0, rr_ptr_r} + 4'(k);
      if (sum >= 4'd5) cand = 3'(sum - 4'd5);
      else             cand = sum[2:0];
      if (!grant_valid_s && !rst && eligible_s[cand]) begin
        grant_valid_s = 1'b1;
        grant_idx_s   = cand;
      end else begin
        grant_valid_s = grant_valid_s;
        grant_idx_s   = grant_idx_s;
      end
    end
    if (grant_valid_s) begin
      grant_s         = 5'd1 << grant_idx_s;
      grant_outport_s = outport_s[grant_idx_s];
    end else begin
      grant_s         = 5'd0;
      grant_outport_s = 5'd0;
    end
  end

  assign sa.sa_grant      = grant_s;
  assign sa.grant_outport = grant_outport_s;
  assign sa.credit_avail  = rst ? 5'b11111 : avail_s;

  // Next-state for round-robin pointer, per-output lock FSMs and credit counters.
  always_comb begin
    if (grant_valid_s) begin
      rr_ptr_next_s = (grant_idx_s == 3'd4) ? 3'd0 : grant_idx_s + 3'd1;
    end else begin
      rr_ptr_next_s = rr_ptr_r;
    end
    for (int o = 0; o < 5; o++) begin
      state_next_s[o]  = state_r[o];
      owner_next_s[o]  = owner_r[o];
      credit_next_s[o] = credit_r[o];
      if (grant_outport_s[o]) begin
        case (state_r[o])
          IDLE: begin
            if (sa.is_head[grant_idx_s] && !sa.is_tail[grant_idx_s]) begin
              state_next_s[o] = LOCKED;
              owner_next_s[o] = grant_idx_s;
            end else begin
              state_next_s[o] = IDLE;
            end
          end
          LOCKED: begin
            if (sa.is_tail[grant_idx_s]) state_next_s[o] = IDLE;
            else                         state_next_s[o] = LOCKED;
          end
          default: state_next_s[o] = IDLE;
        endcase
      end else begin
        state_next_s[o] = state_r[o];
      end
      // A simultaneous grant and credit return cancel out; returns saturate.
      case ({grant_outport_s[o], sa.credit_in[o]})
        2'b10: credit_next_s[o] = credit_r[o] - CRED_ONE;
        2'b01: begin
          if (credit_r[o] != CRED_MAX) credit_next_s[o] = credit_r[o] + CRED_ONE;
          else                         credit_next_s[o] = credit_r[o];
        end
        default: credit_next_s[o] = credit_r[o];
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= 3'd0;
      for (int o = 0; o < 5; o++) begin
        state_r[o]  <= IDLE;
        owner_r[o]  <= 3'd0;
        credit_r[o] <= CRED_MAX;
      end
    end else begin
      rr_ptr_r <= rr_ptr_next_s;
      for (int o = 0; o < 5; o++) begin
        state_r[o]  <= state_next_s[o];
        owner_r[o]  <= owner_next_s[o];
        credit_r[o] <= credit_next_s[o];
      end
    end
  end

`ifdef SA_CREDIT_ERR_EN
  logic overflow_s;
  logic credit_err_r;

  // Credit returned to an output that is already full and not consuming one.
  always_comb begin
    overflow_s = 1'b0;
    for (int o = 0; o < 5; o++) begin
      if (sa.credit_in[o] && credit_r[o] == CRED_MAX && !grant_outport_s[o]) overflow_s = 1'b1;
      else                                                                   overflow_s = overflow_s;
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) credit_err_r <= 1'b0;
    else     credit_err_r <= credit_err_r | overflow_s;
  end

  assign sa.credit_err = credit_err_r;
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// ----------------------------------------------------------------------------
// Directed, table-driven bench for switch_allocator (BUF_DEPTH = 4).
// Inputs are driven just after the falling edge and the combinational outputs
// are compared 1 ns later, well before the next rising edge commits state.
// ----------------------------------------------------------------------------
module tb_switch_allocator;

  localparam logic [4:0] PN = 5'b00001;
  localparam logic [4:0] PE = 5'b00010;
  localparam logic [4:0] PS = 5'b00100;
  localparam logic [4:0] PW = 5'b01000;
  localparam logic [4:0] PL = 5'b10000;
  localparam logic [4:0] Z  = 5'b00000;

  // outport bundle order: {local, west, south, east, north}
  typedef struct {
    logic        rst;
    logic [4:0]  req;
    logic [4:0]  head;
    logic [4:0]  tail;
    logic [24:0] op;
    logic [4:0]  cin;
    logic [4:0]  exp_grant;
    logic [4:0]  exp_gout;
    logic [4:0]  exp_avail;
  } vec_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  vec_t vecs [18];

  sa_if sa_bus ();

  switch_allocator #(.BUF_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .sa  (sa_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [4:0] rq, input logic [4:0] hd,
                              input logic [4:0] tl, input logic [24:0] op,
                              input logic [4:0] ci, input logic [4:0] eg,
                              input logic [4:0] eo, input logic [4:0] ea);
    vec_t v;
    v.rst = r; v.req = rq; v.head = hd; v.tail = tl; v.op = op; v.cin = ci;
    v.exp_grant = eg; v.exp_gout = eo; v.exp_avail = ea;
    return v;
  endfunction

  task automatic check5(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, then let them settle.
  task automatic drive(input logic r, input logic [4:0] rq, input logic [4:0] hd,
                       input logic [4:0] tl, input logic [24:0] op, input logic [4:0] ci);
    @(negedge clk);
    rst                  = r;
    sa_bus.req           = rq;
    sa_bus.is_head       = hd;
    sa_bus.is_tail       = tl;
    sa_bus.outport_north = op[4:0];
    sa_bus.outport_east  = op[9:5];
    sa_bus.outport_south = op[14:10];
    sa_bus.outport_west  = op[19:15];
    sa_bus.outport_local = op[24:20];
    sa_bus.credit_in     = ci;
    #1;
  endtask

  task automatic expect3(input string name, input logic [4:0] eg, input logic [4:0] eo,
                         input logic [4:0] ea);
    check5({name, ".grant"}, sa_bus.sa_grant, eg);
    check5({name, ".outport"}, sa_bus.grant_outport, eo);
    check5({name, ".avail"}, sa_bus.credit_avail, ea);
  endtask

`ifdef SA_CREDIT_ERR_EN
  task automatic check_err(input string name, input logic exp);
    check5(name, {4'd0, sa_bus.credit_err}, {4'd0, exp});
  endtask
`endif

  initial begin
    logic [24:0] rr_op;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    sa_bus.req = Z; sa_bus.is_head = Z; sa_bus.is_tail = Z; sa_bus.credit_in = Z;
    sa_bus.outport_north = Z; sa_bus.outport_east = Z; sa_bus.outport_south = Z;
    sa_bus.outport_west = Z; sa_bus.outport_local = Z;

    rr_op = {PN, PL, PW, PS, PE};
    //                r     req     head    tail    op                   cin  grant   gout  avail
    vecs[0]  = mk(1'b1, 5'b11111, 5'b11111, Z, rr_op,               Z, Z,  Z,  5'b11111);
    vecs[1]  = mk(1'b0, PN,       PN,       Z, {Z, Z, Z, Z, PE},    Z, PN, PE, 5'b11111);
    vecs[2]  = mk(1'b0, PN | PS,  PS,       Z, {Z, Z, PE, Z, PE},   Z, PN, PE, 5'b11111);
    vecs[3]  = mk(1'b0, PS,       PS,       Z, {Z, Z, PE, Z, Z},    Z, Z,  Z,  5'b11111);
    vecs[4]  = mk(1'b0, PN | PS,  PS,       PN, {Z, Z, PE, Z, PE},  Z, PN, PE, 5'b11111);
    vecs[5]  = mk(1'b0, PS,       PS,       Z, {Z, Z, PE, Z, Z},    Z, PS, PE, 5'b11111);
    vecs[6]  = mk(1'b0, Z,        Z,        Z, {Z, Z, Z, Z, Z},     PE, Z, Z,  5'b11101);
    vecs[7]  = mk(1'b0, PS,       Z,        Z, {Z, Z, PE, Z, Z},    Z, PS, PE, 5'b11111);
    vecs[8]  = mk(1'b1, PS,       Z,        Z, {Z, Z, PE, Z, Z},    Z, Z,  Z,  5'b11111);
    vecs[9]  = mk(1'b0, PS,       Z,        Z, {Z, Z, PE, Z, Z},    Z, Z,  Z,  5'b11111);
    vecs[10] = mk(1'b0, PW,       PW,       PW, {Z, 5'b00011, Z, Z, Z}, Z, Z, Z, 5'b11111);
    vecs[11] = mk(1'b0, 5'b11111, 5'b11111, 5'b11111, rr_op,    Z, PN, PE, 5'b11111);
    vecs[12] = mk(1'b0, 5'b11111, 5'b11111, 5'b11111, rr_op,    Z, PE, PS, 5'b11111);
    vecs[13] = mk(1'b0, 5'b11111, 5'b11111, 5'b11111, rr_op,    Z, PS, PW, 5'b11111);
    vecs[14] = mk(1'b0, 5'b11111, 5'b11111, 5'b11111, rr_op,    Z, PW, PL, 5'b11111);
    vecs[15] = mk(1'b0, 5'b11111, 5'b11111, 5'b11111, rr_op,    Z, PL, PN, 5'b11111);
    vecs[16] = mk(1'b0, 5'b11111, 5'b11111, 5'b11111, rr_op,    Z, PN, PE, 5'b11111);
    vecs[17] = mk(1'b1, 5'b11111, 5'b11111, 5'b11111, rr_op,    Z, Z,  Z,  5'b11111);

    for (int n = 0; n < 18; n++) begin
      drive(vecs[n].rst, vecs[n].req, vecs[n].head, vecs[n].tail, vecs[n].op, vecs[n].cin);
      expect3($sformatf("vec%0d", n), vecs[n].exp_grant, vecs[n].exp_gout, vecs[n].exp_avail);
    end

    // Exhaust local credits with single-flit packets, then return one credit.
    for (int n = 0; n < 4; n++) begin
      drive(1'b0, PL, PL, PL, {PL, Z, Z, Z, Z}, Z);
      expect3($sformatf("loc_burst%0d", n), PL, PL, 5'b11111);
    end
    drive(1'b0, PL, PL, PL, {PL, Z, Z, Z, Z}, PL);
    expect3("loc_empty", Z, Z, 5'b01111);
    drive(1'b0, PL, PL, PL, {PL, Z, Z, Z, Z}, Z);
    expect3("loc_refill", PL, PL, 5'b11111);
    drive(1'b0, Z, Z, Z, {Z, Z, Z, Z, Z}, PL);
    expect3("loc_empty2", Z, Z, 5'b01111);

    // Grant plus credit return in the same cycle leaves west's count at 4.
    drive(1'b1, Z, Z, Z, {Z, Z, Z, Z, Z}, Z);
    expect3("rst_b", Z, Z, 5'b11111);
`ifdef SA_CREDIT_ERR_EN
    check_err("err_after_rst", 1'b0);
`endif
    for (int n = 0; n < 5; n++) begin
      drive(1'b0, PW, PW, PW, {Z, PW, Z, Z, Z}, PW);
      expect3($sformatf("west_gc%0d", n), PW, PW, 5'b11111);
    end
    for (int n = 0; n < 4; n++) begin
      drive(1'b0, PW, PW, PW, {Z, PW, Z, Z, Z}, Z);
      expect3($sformatf("west_g%0d", n), PW, PW, 5'b11111);
    end
    drive(1'b0, PW, PW, PW, {Z, PW, Z, Z, Z}, Z);
    expect3("west_empty", Z, Z, 5'b10111);
`ifdef SA_CREDIT_ERR_EN
    check_err("err_no_overflow", 1'b0);
    // Credit returned at full count with no grant: sticky error until reset.
    drive(1'b1, Z, Z, Z, {Z, Z, Z, Z, Z}, Z);
    drive(1'b0, Z, Z, Z, {Z, Z, Z, Z, Z}, PW);
    check_err("err_same_cycle", 1'b0);
    for (int n = 0; n < 4; n++) begin
      drive(1'b0, Z, Z, Z, {Z, Z, Z, Z, Z}, Z);
      check_err($sformatf("err_sticky%0d", n), 1'b1);
    end
    drive(1'b1, Z, Z, Z, {Z, Z, Z, Z, Z}, Z);
    drive(1'b0, Z, Z, Z, {Z, Z, Z, Z, Z}, Z);
    check_err("err_cleared", 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
